keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Matrix-keypad reader for the board's 5x4 keypad; drives K_ROW and samples K_COL.
- Replaces direct K_ROW/K_COL handling at framework_sch top level; feeds debounced key events to game logic.
- Scans rows one at a time, locks onto a pressed key, debounces press and release, emits one-cycle event pulses plus a held level.

Parameters:
- SCAN_DIV, 100000, clk_100mhz cycles per row dwell (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive agreeing samples (ticks) needed to accept a press or release; must be >= 2.

Ports:
- clk_100mhz  in  1  system clock, 100 MHz.
- RSTN  in  1  asynchronous, active-low reset.
- K_COL  in  4  keypad columns, active-low (pulled up; 0 = key closed on the driven row).
- K_ROW  out  5  keypad rows, one-hot active-low (driven row = 0, others = 1).
- key_code  out  5  last accepted key, row*4+col, range 0..19.
- key_valid  out  1  one-cycle pulse when a press is accepted; key_code is valid in the same cycle.
- key_held  out  1  high from key_valid until the release is accepted.
- key_release  out  1  one-cycle pulse when the release is accepted.

Behaviour:
- Interface: one clock, clk_100mhz; reset RSTN is asynchronous and active-low.
- Reset values: K_ROW=5'b11110 (row 0), key_code=0, key_valid=0, key_held=0, key_release=0, divider=0, state=SCAN, debounce count=0.
- K_COL passes through a 2-FF synchronizer (reset to 4'b1111) before any use.
- Tick: divider counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where divider==SCAN_DIV-1. All sampling and row changes occur only on tick.
- Sample: on tick, the synchronized K_COL reflects the row driven during the whole preceding dwell. hit = any bit low. col = lowest index low bit (multi-key tie-break).
- SCAN: on tick with no hit, advance to the next row: 0->1->2->3->4->0. On tick with hit, hold the row, capture cand=row*4+col, set count=1, go to DB_PRESS.
- DB_PRESS: K_ROW frozen. On tick with the same col low, count++. On tick with no hit or a different lowest col, go to SCAN and advance the row.
- DB_PRESS accept: when count reaches DEBOUNCE_SCANS, in the next cycle key_code<=cand, key_valid=1 for that one cycle, key_held<=1, go to HELD.
- HELD: K_ROW frozen. On tick, if the locked column is high, set count=1 and go to DB_REL. Other columns are ignored.
- DB_REL: on tick with the locked column high, count++. If the locked column is low again, go back to HELD with no pulse.
- DB_REL accept: when count reaches DEBOUNCE_SCANS, key_release=1 for one cycle, key_held<=0, go to SCAN and advance the row on the same transition.
- key_code holds its value until the next accepted press; it is never cleared except by reset.
- key_valid and key_release are never high in the same cycle.
- Worst-case press latency: 5 row dwells plus DEBOUNCE_SCANS ticks plus 3 cycles.
- Keys on other rows are invisible while locked.
- Reset asserted in any state forces reset values immediately; no pulse is generated on reset exit.

Decomposition:
- keypad_pkg holds ROWS=5, COLS=4, CODE_W=5, and the state encoding {SCAN, DB_PRESS, HELD, DB_REL}.
- One sub-module, scan_tick_gen: parameterized SCAN_DIV divider with async active-low reset, output tick.
- The synchronizer and FSM stay in keypad_scanner.

Test Plan:
- Bench setup: SCAN_DIV=4, DEBOUNCE_SCANS=3. Keypad model: K_COL[c]=0 iff key (r,c) is pressed and K_ROW[r]==0.
- Reset/rotation: RSTN=0 for 50 ns, then release with no keys -> all outputs 0. K_ROW cycles 11110,11101,11011,10111,01111,11110, changing every 4 clocks.
- Clean press: hold key (2,1) -> K_ROW freezes at 11011. Exactly one key_valid pulse with key_code=9. key_held=1 and stays high while the key is held.
- Bounce: key (2,1) closed for only 1 tick, then opened -> no key_valid; K_ROW resumes rotating from 10111.
- Release: after the clean press, open the key -> key_release pulses once, 3 ticks after opening. key_held=0, key_code remains 9, scanning resumes. A 1-tick reopen glitch during DB_REL produces no pulse.
- Multi-key: hold (4,0) and (4,3) together -> key_code=16. From reset, hold (0,2) and (3,1) together -> key_code=2, and (3,1) is ignored until (0,2) is released.
- Reset mid-HELD: assert RSTN while key_held=1 -> K_ROW=11110 and key_held/key_code=0 asynchronously. With the key still held after release, a new key_valid follows.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state encoding and small helpers for the
// 5x4 matrix keypad scanner.
//   ROWS/COLS   keypad geometry
//   CODE_W      width of key_code (row*4+col, 0..19)
//   state_e     scanner FSM states
package keypad_pkg;

  localparam int ROWS   = 5;
  localparam int COLS   = 4;
  localparam int CODE_W = 5;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_e;

  // Lowest-index low column; only meaningful when at least one bit is low.
  function automatic logic [COL_W-1:0] lowest_low_col(input logic [COLS-1:0] col);
    if (!col[0]) begin
      return 2'd0;
    end else if (!col[1]) begin
      return 2'd1;
    end else if (!col[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  // Row rotation 0->1->2->3->4->0.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    if (row == 3'(ROWS - 1)) begin
      return 3'd0;
    end else begin
      return row + 3'd1;
    end
  endfunction

  // One-hot active-low row drive pattern.
  function automatic logic [ROWS-1:0] row_drive_n(input logic [ROW_W-1:0] row);
    case (row)
      3'd0:    return 5'b11110;
      3'd1:    return 5'b11101;
      3'd2:    return 5'b11011;
      3'd3:    return 5'b10111;
      3'd4:    return 5'b01111;
      default: return 5'b11110;
    endcase
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: row-dwell divider. Counts 0..SCAN_DIV-1 and wraps; tick is
// high for the one cycle in which the counter sits at SCAN_DIV-1.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (counter -> 0, tick -> 0)
//   tick   out  registered one-cycle dwell-end strobe
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next divider value; tick is precomputed so it lines up with cnt==LAST.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Divider and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 active-low matrix keypad one row per dwell,
// locks onto the first pressed key found, debounces press and release, and
// reports key events.
//   clk_100mhz   in   system clock
//   RSTN         in   asynchronous active-low reset
//   K_COL[3:0]   in   keypad columns, active-low, asynchronous to clk
//   K_ROW[4:0]   out  one-hot active-low row drive
//   key_code     out  last accepted key (row*4+col), held until next press
//   key_valid    out  one-cycle pulse on accepted press
//   key_held     out  high from key_valid until release is accepted
//   key_release  out  one-cycle pulse on accepted release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk_100mhz,
  input  logic              RSTN,
  input  logic [COLS-1:0]   K_COL,
  output logic [ROWS-1:0]   K_ROW,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release
);

  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic tick_s;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk   (clk_100mhz),
    .rst_n (RSTN),
    .tick  (tick_s)
  );

  logic [COLS-1:0]   col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROWS-1:0]   k_row_q, k_row_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [COL_W-1:0]  lock_col_q, lock_col_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              key_release_q, key_release_d;

  logic              hit_s;
  logic [COL_W-1:0]  col_s;
  logic              lock_high_s;

  // Column decode from the synchronized sample.
  always_comb begin
    hit_s       = ~(&col_s2_q);
    col_s       = lowest_low_col(col_s2_q);
    lock_high_s = col_s2_q[lock_col_q];
  end

  // Next-state logic: synchronizer shift, scan/debounce FSM, event outputs.
  // Accept is checked before tick so the pulse lands one cycle after the
  // debounce count completes; ticks are never back-to-back.
  always_comb begin
    col_s1_d      = K_COL;
    col_s2_d      = col_s1_q;
    state_d       = state_q;
    row_d         = row_q;
    cand_d        = cand_q;
    lock_col_d    = lock_col_q;
    db_cnt_d      = db_cnt_q;
    key_code_d    = key_code_q;
    key_held_d    = key_held_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (tick_s) begin
          if (hit_s) begin
            cand_d     = {row_q, col_s};
            lock_col_d = col_s;
            db_cnt_d   = DB_ONE;
            state_d    = DB_PRESS;
          end else begin
            row_d = next_row(row_q);
          end
        end else begin
          state_d = SCAN;
        end
      end

      DB_PRESS: begin
        if (db_cnt_q == DB_DONE) begin
          key_code_d  = cand_q;
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else if (tick_s) begin
          if (hit_s && (col_s == lock_col_q)) begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end else begin
            db_cnt_d = '0;
            row_d    = next_row(row_q);
            state_d  = SCAN;
          end
        end else begin
          state_d = DB_PRESS;
        end
      end

      HELD: begin
        // Only the locked column matters; other keys on this row are ignored.
        if (tick_s) begin
          if (lock_high_s) begin
            db_cnt_d = DB_ONE;
            state_d  = DB_REL;
          end else begin
            state_d = HELD;
          end
        end else begin
          state_d = HELD;
        end
      end

      DB_REL: begin
        if (db_cnt_q == DB_DONE) begin
          key_release_d = 1'b1;
          key_held_d    = 1'b0;
          db_cnt_d      = '0;
          row_d         = next_row(row_q);
          state_d       = SCAN;
        end else if (tick_s) begin
          if (lock_high_s) begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end else begin
            db_cnt_d = '0;
            state_d  = HELD;
          end
        end else begin
          state_d = DB_REL;
        end
      end

      default: begin
        state_d    = SCAN;
        row_d      = 3'd0;
        db_cnt_d   = '0;
        key_held_d = 1'b0;
      end
    endcase

    k_row_d = row_drive_n(row_d);
  end

  // State and output registers.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      col_s1_q      <= 4'b1111;
      col_s2_q      <= 4'b1111;
      state_q       <= SCAN;
      row_q         <= 3'd0;
      k_row_q       <= 5'b11110;
      cand_q        <= 5'd0;
      lock_col_q    <= 2'd0;
      db_cnt_q      <= '0;
      key_code_q    <= 5'd0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      col_s1_q      <= col_s1_d;
      col_s2_q      <= col_s2_d;
      state_q       <= state_d;
      row_q         <= row_d;
      k_row_q       <= k_row_d;
      cand_q        <= cand_d;
      lock_col_q    <= lock_col_d;
      db_cnt_q      <= db_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  assign K_ROW       = k_row_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed, table-driven bench for keypad_scanner with
// SCAN_DIV=4 and DEBOUNCE_SCANS=3, using a combinational keypad model.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  k_col;
  logic [4:0]  k_row;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;
  logic [19:0] pressed;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int valid_cnt = 0;
  int rel_cnt   = 0;
  int both_cnt  = 0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk_100mhz  (clk),
    .RSTN        (rst_n),
    .K_COL       (k_col),
    .K_ROW       (k_row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: column c pulled low when a pressed key on a driven row sits on it.
  always_comb begin
    k_col = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 5; r++) begin
        if (pressed[r*4+c] && !k_row[r]) k_col[c] = 1'b0;
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid) valid_cnt = valid_cnt + 1;
    if (key_release) rel_cnt = rel_cnt + 1;
    if (key_valid && key_release) both_cnt = both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [19:0] keybit(input int r, input int c);
    logic [19:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Wait for the valid (which=0) or release (which=1) counter to move past prev.
  task automatic wait_evt(input string name, input int which, input int prev,
                          input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc(1);
      if (((which == 0) ? valid_cnt : rel_cnt) != prev) begin
        lat = i;
        break;
      end
    end
    chk({name, "_seen"}, 32'(lat > 0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    pressed = '0;
    #50;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [19:0] mask;
    logic [4:0]  code;
    logic [4:0]  row;
  } vec_t;

  vec_t       tbl[6];
  logic [4:0] seq[6];
  int         lat;
  int         v0;
  int         r0;
  int         seen;

  initial begin
    tbl[0] = '{keybit(4, 0) | keybit(4, 3), 5'd16, 5'b01111};
    tbl[1] = '{keybit(0, 3), 5'd3,  5'b11110};
    tbl[2] = '{keybit(1, 0), 5'd4,  5'b11101};
    tbl[3] = '{keybit(3, 2), 5'd14, 5'b10111};
    tbl[4] = '{keybit(4, 3), 5'd19, 5'b01111};
    tbl[5] = '{keybit(0, 0), 5'd0,  5'b11110};
    seq[0] = 5'b11110; seq[1] = 5'b11101; seq[2] = 5'b11011;
    seq[3] = 5'b10111; seq[4] = 5'b01111; seq[5] = 5'b11110;

    // Reset values, checked while reset is still asserted.
    rst_n   = 1'b0;
    pressed = '0;
    #20;
    chk("rst_k_row", k_row, 5'b11110);
    chk("rst_code", key_code, 5'd0);
    chk("rst_held", key_held, 1'b0);
    do_reset();
    chk("post_rst_valid", key_valid, 1'b0);
    chk("post_rst_release", key_release, 1'b0);
    chk("post_rst_k_row", k_row, 5'b11110);

    // Row rotation, one change every 4 clocks.
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (k_row != 5'b11110) begin
        seen = 1;
        break;
      end
    end
    chk("rot_start_seen", seen, 1);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("rot_row%0d_enter", i), k_row, seq[i]);
      cyc(3);
      chk($sformatf("rot_row%0d_dwell", i), k_row, seq[i]);
      cyc(1);
    end
    chk("rot_no_valid", valid_cnt, 0);
    chk("rot_no_release", rel_cnt, 0);

    // Bounce: key (2,1) closed for one dwell only.
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (k_row == 5'b11011) begin
        seen = 1;
        break;
      end
      cyc(1);
    end
    chk("bounce_row2_seen", seen, 1);
    v0 = valid_cnt;
    pressed = keybit(2, 1);
    cyc(4);
    chk("bounce_frozen", k_row, 5'b11011);
    pressed = '0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (k_row != 5'b11011) begin
        seen = 1;
        break;
      end
    end
    chk("bounce_resume_seen", seen, 1);
    chk("bounce_resume_row", k_row, 5'b10111);
    cyc(20);
    chk("bounce_no_valid", valid_cnt, v0);

    // Clean press of (2,1), release glitch, then real release.
    v0 = valid_cnt;
    pressed = keybit(2, 1);
    wait_evt("press9", 0, v0, 80, lat);
    chk("press9_code", key_code, 5'd9);
    chk("press9_held", key_held, 1'b1);
    chk("press9_row", k_row, 5'b11011);
    cyc(40);
    chk("press9_single", valid_cnt, v0 + 1);
    chk("press9_still_held", key_held, 1'b1);
    chk("press9_row_frozen", k_row, 5'b11011);
    r0 = rel_cnt;
    pressed = '0;
    cyc(4);
    pressed = keybit(2, 1);
    cyc(30);
    chk("glitch_no_release", rel_cnt, r0);
    chk("glitch_held", key_held, 1'b1);
    chk("glitch_no_valid", valid_cnt, v0 + 1);
    pressed = '0;
    wait_evt("rel9", 1, r0, 40, lat);
    chk("rel9_latency_ok", 32'((lat >= 10) && (lat <= 18)), 32'd1);
    chk("rel9_held", key_held, 1'b0);
    chk("rel9_code_kept", key_code, 5'd9);
    chk("rel9_row_advance", k_row, 5'b10111);
    cyc(10);
    chk("rel9_single", rel_cnt, r0 + 1);

    // Table of press/release vectors.
    for (int t = 0; t < 6; t++) begin
      v0 = valid_cnt;
      pressed = tbl[t].mask;
      wait_evt($sformatf("tbl%0d_press", t), 0, v0, 80, lat);
      chk($sformatf("tbl%0d_code", t), key_code, tbl[t].code);
      chk($sformatf("tbl%0d_row", t), k_row, tbl[t].row);
      chk($sformatf("tbl%0d_held", t), key_held, 1'b1);
      cyc(20);
      chk($sformatf("tbl%0d_single", t), valid_cnt, v0 + 1);
      r0 = rel_cnt;
      pressed = '0;
      wait_evt($sformatf("tbl%0d_rel", t), 1, r0, 40, lat);
      chk($sformatf("tbl%0d_rel_held", t), key_held, 1'b0);
      chk($sformatf("tbl%0d_code_kept", t), key_code, tbl[t].code);
      cyc(8);
    end

    // Two keys on different rows from reset: row 0 wins, row 3 waits.
    do_reset();
    v0 = valid_cnt;
    pressed = keybit(0, 2) | keybit(3, 1);
    wait_evt("multi_press", 0, v0, 80, lat);
    chk("multi_code", key_code, 5'd2);
    chk("multi_row", k_row, 5'b11110);
    cyc(60);
    chk("multi_ignored", valid_cnt, v0 + 1);
    chk("multi_code_hold", key_code, 5'd2);
    r0 = rel_cnt;
    pressed = keybit(3, 1);
    wait_evt("multi_rel", 1, r0, 40, lat);
    v0 = valid_cnt;
    wait_evt("multi_second", 0, v0, 80, lat);
    chk("multi_second_code", key_code, 5'd13);
    chk("multi_second_row", k_row, 5'b10111);
    r0 = rel_cnt;
    pressed = '0;
    wait_evt("multi_second_rel", 1, r0, 40, lat);

    // Reset while a key is held, with the key still down afterwards.
    v0 = valid_cnt;
    pressed = keybit(2, 1);
    wait_evt("rstheld_press", 0, v0, 80, lat);
    chk("rstheld_held_before", key_held, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstheld_k_row", k_row, 5'b11110);
    chk("rstheld_held", key_held, 1'b0);
    chk("rstheld_code", key_code, 5'd0);
    #48;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v0 = valid_cnt;
    wait_evt("rstheld_repress", 0, v0, 80, lat);
    chk("rstheld_repress_code", key_code, 5'd9);
    r0 = rel_cnt;
    pressed = '0;
    wait_evt("rstheld_rel", 1, r0, 40, lat);

    chk("valid_release_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
